// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bits needed to hold an iteration count of 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Two's-complement magnitude of the low 'width' bits of v.
  // The most negative value maps to 2^(width-1), which still fits unsigned.
  function automatic logic [63:0] twos_mag(input logic [63:0] v, input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    if (v[width-1]) return (~v + 64'd1) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand / result handshake bundle for seq_shift_add_multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, signed_mode, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, signed_mode, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult_add_step.sv
// One radix-2 iteration: conditional add of the multiplicand into the upper
// accumulator half, then a right shift of the whole {acc_hi, acc_lo} pair.
module mult_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);
  logic [WIDTH:0] sum;

  // acc_lo holds the not-yet-consumed multiplier bits; its LSB gates the add.
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one multiplier bit per clock,
// unsigned or two's-complement per operation, valid/ready on both sides.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               neg;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product_r;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_mag;
  logic               last;
  logic               accept;

  assign last     = (count == CW'(WIDTH - 1));
  assign accept   = bus.in_valid && (state == IDLE);
  assign prod_mag = {step_hi, step_lo};

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_r;

  // Operand magnitudes; raw operands pass through in unsigned mode.
  always_comb begin
    mag_a = bus.signed_mode ? WIDTH'(twos_mag(64'(bus.a), WIDTH)) : bus.a;
    mag_b = bus.signed_mode ? WIDTH'(twos_mag(64'(bus.b), WIDTH)) : bus.b;
  end

  mult_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .mcand  (mcand),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: IDLE -> RUN for WIDTH cycles -> DONE until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, iteration in RUN, signed fix-up on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      neg       <= 1'b0;
      count     <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= mag_a;
            acc_hi <= '0;
            acc_lo <= mag_b;
            neg    <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            count  <= '0;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CW'(1);
          if (last) product_r <= neg ? -prod_mag : prod_mag;
        end
        default: ;
      endcase
    end
  end
endmodule
